// File: rtl/program_loader.sv
// program_loader: streams a little-endian byte image into instruction memory and holds the CPU in reset until it loads cleanly
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   start                 one-cycle pulse that begins a new load from IDLE, DONE or ERROR
//   in_valid/in_data/in_last/in_ready   byte stream handshake; in_last marks the final byte
//   mem_we/mem_addr/mem_wdata           word write port, word-aligned addresses from 0
//   cpu_reset, done, error, word_count  load status
module program_loader #(
   parameter int MEM_BYTES = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_reset,
   output logic        done,
   output logic        error,
   output logic [31:0] word_count
);
   typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERROR} state_t;
   state_t     r_state;
   logic [1:0] r_idx;
   logic       r_last;
   logic       w_xfer;
   logic       w_ovf;
   assign w_xfer = in_valid && in_ready;
   // widened by one bit so an address near 2^32 cannot wrap past the size check
   assign w_ovf  = ({1'b0, mem_addr} + 33'd4) > 33'(MEM_BYTES);
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_idx      <= 2'd0;
         r_last     <= 1'b0;
         in_ready   <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 32'd0;
         mem_wdata  <= 32'd0;
         cpu_reset  <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
         word_count <= 32'd0;
      end else begin
         case (r_state)
            IDLE, DONE, ERROR: if (start) begin
               r_state    <= LOAD;
               r_idx      <= 2'd0;
               mem_addr   <= 32'd0;
               word_count <= 32'd0;
               done       <= 1'b0;
               error      <= 1'b0;
               cpu_reset  <= 1'b1;
               in_ready   <= 1'b1;
            end
            LOAD: if (w_xfer) begin
               mem_wdata[{r_idx, 3'b000} +: 8] <= in_data;
               r_idx <= r_idx + 2'd1;
               if (r_idx == 2'd3) begin
                  in_ready <= 1'b0;
                  r_last   <= in_last;
                  if (w_ovf) begin
                     r_state <= ERROR;
                     error   <= 1'b1;
                  end else begin
                     r_state <= WRITE;
                     mem_we  <= 1'b1;
                  end
               end else if (in_last) begin
                  // a truncated final word is discarded rather than padded
                  r_state  <= ERROR;
                  error    <= 1'b1;
                  in_ready <= 1'b0;
               end
            end
            WRITE: begin
               mem_we     <= 1'b0;
               mem_addr   <= mem_addr + 32'd4;
               word_count <= word_count + 32'd1;
               if (r_last) begin
                  r_state   <= DONE;
                  done      <= 1'b1;
                  cpu_reset <= 1'b0;
               end else begin
                  r_state  <= LOAD;
                  in_ready <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench driving a 1024-byte and an 8-byte loader from one shared byte stream
module tb_program_loader;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic in_valid = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic in_last = 1'b0;
   logic d0_in_ready, d0_mem_we, d0_cpu_reset, d0_done, d0_error;
   logic [31:0] d0_mem_addr, d0_mem_wdata, d0_word_count;
   logic d1_in_ready, d1_mem_we, d1_cpu_reset, d1_done, d1_error;
   logic [31:0] d1_mem_addr, d1_mem_wdata, d1_word_count;
   int total = 0;
   int passed = 0;
   logic [7:0] img[$];
   logic [63:0] exp0[$];
   logic [63:0] exp1[$];
   bit exp_done[2];
   bit exp_err[2];
   int exp_wc[2];

   always #5 clock = ~clock;

   program_loader #(.MEM_BYTES(1024)) dut0 (
      .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(d0_in_ready), .mem_we(d0_mem_we), .mem_addr(d0_mem_addr), .mem_wdata(d0_mem_wdata),
      .cpu_reset(d0_cpu_reset), .done(d0_done), .error(d0_error), .word_count(d0_word_count));

   program_loader #(.MEM_BYTES(8)) dut1 (
      .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(d1_in_ready), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata),
      .cpu_reset(d1_cpu_reset), .done(d1_done), .error(d1_error), .word_count(d1_word_count));

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s actual=%h required=%h", name, act, req);
   endtask

   // memory-image model: whole words are written in order until one would not fit; a trailing partial word is an error
   task automatic model(input int d, input int mem);
      int n = img.size();
      int wc = 0;
      bit err = 0;
      for (int w = 0; (w * 4 + 4 <= n) && !err; w++) begin
         if (w * 4 + 4 > mem) err = 1;
         else begin
            if (d == 0) exp0.push_back({32'(w * 4), img[w*4+3], img[w*4+2], img[w*4+1], img[w*4]});
            else exp1.push_back({32'(w * 4), img[w*4+3], img[w*4+2], img[w*4+1], img[w*4]});
            wc++;
         end
      end
      if (n % 4 != 0) err = 1;
      exp_done[d] = !err;
      exp_err[d] = err;
      exp_wc[d] = wc;
   endtask

   always @(negedge clock) begin
      if (d0_mem_we) begin
         if (exp0.size() == 0) begin
            total++;
            $display("FAIL d0_write actual=%h:%h required=no write", d0_mem_addr, d0_mem_wdata);
         end else chk("d0_write", {d0_in_ready, d0_cpu_reset, d0_mem_addr, d0_mem_wdata}, {2'b01, exp0.pop_front()});
      end
      if (d1_mem_we) begin
         if (exp1.size() == 0) begin
            total++;
            $display("FAIL d1_write actual=%h:%h required=no write", d1_mem_addr, d1_mem_wdata);
         end else chk("d1_write", {d1_in_ready, d1_cpu_reset, d1_mem_addr, d1_mem_wdata}, {2'b01, exp1.pop_front()});
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic send(input bit gaps, input bit mid, input bit last_end);
      bit ok;
      for (int i = 0; i < img.size(); i++) begin
         if (gaps) repeat ($urandom_range(0, 3)) begin
            in_valid = 1'b0;
            in_data = 8'($urandom);
            in_last = 1'($urandom);
            @(posedge clock); #1;
         end
         if (mid && i == 5) begin
            in_valid = 1'b0;
            in_last = 1'b0;
            pulse_start();
         end
         in_valid = 1'b1;
         in_data = img[i];
         in_last = last_end && (i == img.size() - 1);
         ok = 0;
         for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clock);
            ok = d0_in_ready;
            @(posedge clock); #1;
         end
         if (!ok) chk("xfer_timeout", 0, 1);
      end
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic finish_chk();
      bit ok = 0;
      for (int c = 0; c < 30 && !ok; c++) begin
         @(negedge clock);
         ok = (d0_done || d0_error) && (d1_done || d1_error);
      end
      chk("d0_final", {d0_done, d0_error, d0_cpu_reset, d0_word_count}, {exp_done[0], exp_err[0], !exp_done[0], 32'(exp_wc[0])});
      chk("d1_final", {d1_done, d1_error, d1_cpu_reset, d1_word_count}, {exp_done[1], exp_err[1], !exp_done[1], 32'(exp_wc[1])});
      chk("d0_pending", exp0.size(), 0);
      chk("d1_pending", exp1.size(), 0);
      @(posedge clock); #1;
   endtask

   task automatic run(input bit gaps, input bit mid);
      pulse_start();
      model(0, 1024);
      model(1, 8);
      send(gaps, mid, 1);
      finish_chk();
   endtask

   task automatic rand_img(input int n);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(8'($urandom));
   endtask

   initial begin
      repeat (3) @(posedge clock);
      #1;
      chk("reset_outputs", {d0_in_ready, d0_mem_we, d0_cpu_reset, d0_done, d0_error, d0_word_count, d0_mem_addr, d0_mem_wdata},
          {5'b00100, 96'd0});
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      chk("idle_after_reset", {d0_in_ready, d0_cpu_reset, d0_done, d0_error}, 4'b0100);
      img = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
      run(0, 0);
      chk("given_word_count", d0_word_count, 2);
      img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      run(0, 0);
      rand_img(12);
      pulse_start();
      model(0, 1024);
      model(1, 8);
      send(1, 0, 1);
      chk("ovf_error_timing", {d1_error, d1_mem_we, d0_mem_we}, 3'b101);
      finish_chk();
      rand_img(16);
      run(1, 1);
      rand_img(20);
      run(1, 0);
      img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      pulse_start();
      send(0, 0, 0);
      chk("write_before_reset", {d0_mem_we, d0_in_ready}, 2'b10);
      #2 reset = 1'b1;
      #1;
      chk("d0_reset_async", {d0_in_ready, d0_mem_we, d0_cpu_reset, d0_done, d0_error, d0_word_count, d0_mem_addr, d0_mem_wdata},
          {5'b00100, 96'd0});
      chk("d1_reset_async", {d1_mem_we, d1_cpu_reset, d1_word_count}, {2'b01, 32'd0});
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      chk("no_write_after_reset", exp0.size() + exp1.size(), 0);
      img = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
      run(0, 0);
      img = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      pulse_start();
      chk("restart_status", {d0_done, d0_cpu_reset, d0_in_ready}, 3'b011);
      model(0, 1024);
      model(1, 8);
      send(0, 0, 1);
      finish_chk();
      chk("reload_word_count", d0_word_count, 1);
      repeat (3) @(posedge clock);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
